// File: rtl/bitcell_array_pkg.sv
// Shared definitions for the bit-cell array access controller.
//   - state_e       : controller FSM states
//   - DEF_DATA_W    : default bits per word
//   - DEF_ADDR_W    : default word address width
//   - PAR_BITS      : extra parity cells per word (1 when
//                     BITCELL_ARRAY_CTRL_PARITY_EN is defined, else 0)
//   - even_parity() : XOR reduction helper
package bitcell_array_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_STROBE = 2'd1,
    RD_STROBE = 2'd2,
    RESP      = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 2;

`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Fixed argument width so one function serves any word width;
  // callers zero-extend, which does not change the XOR result.
  localparam int PAR_FN_W = 32;

  function automatic logic even_parity(input logic [PAR_FN_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/bitcell_addr_decode.sv
// Combinational ADDR_W-to-WORDS one-hot decoder with enable.
//   en     : when 0 the output is all zeros
//   addr   : word address
//   onehot : one-hot select, bit [addr] set when en=1
module bitcell_addr_decode #(
  parameter int ADDR_W = 2,
  parameter int WORDS  = 2**ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORDS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// Access initiator for a word-organised array of one-bit storage cells.
// Accepts host read/write requests and sequences the cell strobes
// (one-hot cs per word, shared w/r/din), then returns read data or a
// write acknowledge.
//
// Optional feature macro: BITCELL_ARRAY_CTRL_PARITY_EN
//   adds one even-parity cell per word (cell_din/cell_dout become
//   DATA_W+1 bits, MSB = parity) and a registered rsp_perr output.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (req_ready = state is IDLE)
//   req_we/addr/wdata     : request fields, held by the host until accepted
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_we     : response payload (rdata is 0 for a write ack)
//   cell_cs/w/r/din       : registered array control pins
//   cell_dout             : shared tristate read bus, sampled in RD_STROBE only
//   rsp_perr              : parity error flag (parity build only)
//
// Handshake rule: a transfer happens on a rising edge where valid and
// ready are both high; a producer holds its payload stable while valid
// is high and ready is low.
module bitcell_array_ctrl
  import bitcell_array_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int WORDS  = 2**ADDR_W,
  localparam int CELL_W = DATA_W + PAR_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we,
  output logic [WORDS-1:0]  cell_cs,
  output logic              cell_w,
  output logic              cell_r,
  output logic [CELL_W-1:0] cell_din,
  input  logic [CELL_W-1:0] cell_dout
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
  ,
  output logic              rsp_perr
`endif
);

  state_e              state_q, state_d;
  logic [WORDS-1:0]    cell_cs_q, cell_cs_d;
  logic                cell_w_q, cell_w_d;
  logic                cell_r_q, cell_r_d;
  logic [CELL_W-1:0]   cell_din_q, cell_din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_we_q, rsp_we_d;
  logic [WORDS-1:0]    dec_onehot;
  logic                accept;
  logic [CELL_W-1:0]   wr_word;
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
  logic                rsp_perr_q, rsp_perr_d;
`endif

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // The request is decoded while still on the host bus so the strobe
  // registers already hold the access during the cycle after acceptance.
  // These registers are therefore the latched copy of addr/we/wdata.
  bitcell_addr_decode #(
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS)
  ) u_decode (
    .en     (accept),
    .addr   (req_addr),
    .onehot (dec_onehot)
  );

`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
  assign wr_word = {even_parity(PAR_FN_W'(req_wdata)), req_wdata};
`else
  assign wr_word = req_wdata;
`endif

  always_comb begin
    state_d     = state_q;
    // Strobes are single-cycle pulses: they default low every cycle.
    cell_cs_d   = '0;
    cell_w_d    = 1'b0;
    cell_r_d    = 1'b0;
    cell_din_d  = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_we_d    = rsp_we_q;
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
    rsp_perr_d  = rsp_perr_q;
`endif

    case (state_q)
      IDLE: begin
        rsp_valid_d = 1'b0;
        if (accept) begin
          cell_cs_d = dec_onehot;
          if (req_we) begin
            state_d    = WR_STROBE;
            cell_w_d   = 1'b1;
            cell_din_d = wr_word;
          end else begin
            state_d  = RD_STROBE;
            cell_r_d = 1'b1;
          end
        end
      end

      // Cells capture cell_din on the edge that leaves this state.
      WR_STROBE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_we_d    = 1'b1;
        rsp_rdata_d = '0;
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
        rsp_perr_d  = 1'b0;
`endif
      end

      // The only state where the selected word drives cell_dout.
      RD_STROBE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_we_d    = 1'b0;
        rsp_rdata_d = cell_dout[DATA_W-1:0];
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
        rsp_perr_d  = even_parity(PAR_FN_W'(cell_dout));
`endif
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cell_cs_q   <= '0;
      cell_w_q    <= 1'b0;
      cell_r_q    <= 1'b0;
      cell_din_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cell_cs_q   <= cell_cs_d;
      cell_w_q    <= cell_w_d;
      cell_r_q    <= cell_r_d;
      cell_din_q  <= cell_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_perr_q <= 1'b0;
    end else begin
      rsp_perr_q <= rsp_perr_d;
    end
  end

  assign rsp_perr = rsp_perr_q;
`endif

  assign cell_cs   = cell_cs_q;
  assign cell_w    = cell_w_q;
  assign cell_r    = cell_r_q;
  assign cell_din  = cell_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_we    = rsp_we_q;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Testbench for bitcell_array_ctrl: a behavioural cell array drives
// cell_dout, a word-level memory model predicts every response, and
// directed plus randomized scenarios exercise reset, sweep, backpressure
// and back-to-back issue. Build with BITCELL_ARRAY_CTRL_PARITY_EN to add
// the parity scenario.
module tb_bitcell_array_ctrl;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int WORDS  = 4;
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
  localparam int CW = DATA_W + 1;
`else
  localparam int CW = DATA_W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we    = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_we;
  logic [WORDS-1:0]  cell_cs;
  logic              cell_w;
  logic              cell_r;
  logic [CW-1:0]     cell_din;
  logic [CW-1:0]     cell_dout;
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
  logic              rsp_perr;
`endif

  int n_vec = 0;
  int n_err = 0;

  bitcell_array_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_we    (rsp_we),
    .cell_cs   (cell_cs),
    .cell_w    (cell_w),
    .cell_r    (cell_r),
    .cell_din  (cell_din),
    .cell_dout (cell_dout)
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
    ,
    .rsp_perr  (rsp_perr)
`endif
  );

  // ---------------- behavioural cell array ----------------
  logic [CW-1:0] cells [WORDS];
  logic          force_msb0 = 1'b0;
  logic [CW-1:0] dout_drv;

  initial begin
    for (int i = 0; i < WORDS; i++) cells[i] = '0;
  end

  always @(posedge clk) begin
    if (cell_w) begin
      for (int i = 0; i < WORDS; i++) begin
        if (cell_cs[i]) cells[i] <= cell_din;
      end
    end
  end

  always_comb begin
    dout_drv = 'z;
    if (cell_r) begin
      for (int i = 0; i < WORDS; i++) begin
        if (cell_cs[i]) dout_drv = cells[i];
      end
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
      if (force_msb0) dout_drv[CW-1] = 1'b0;
`endif
    end
  end

  assign cell_dout = dout_drv;

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              frc;
  } req_t;

  req_t              pend_q[$];
  logic [DATA_W-1:0] mem [WORDS];

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        pend_q.push_back('{we: req_we, addr: req_addr, data: req_wdata, frc: force_msb0});
      end
      if (rsp_valid && rsp_ready) begin
        n_vec++;
        if (pend_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding request at cycle %0d", cyc);
        end else begin
          req_t r;
          logic              exp_we;
          logic [DATA_W-1:0] exp_data;
          logic              exp_perr;
          r = pend_q.pop_front();
          if (r.we) begin
            mem[r.addr] = r.data;
            exp_we   = 1'b1;
            exp_data = '0;
            exp_perr = 1'b0;
          end else begin
            exp_we   = 1'b0;
            exp_data = mem[r.addr];
            // Stored parity is ^data; forcing the parity cell to 0 makes
            // the full word's parity equal ^data.
            exp_perr = r.frc ? (^mem[r.addr]) : 1'b0;
          end
          if (rsp_we !== exp_we || rsp_rdata !== exp_data) begin
            n_err++;
            $display("FAIL rsp_payload: got we=%0b rdata=%h, expected we=%0b rdata=%h (addr %0d)",
                     rsp_we, rsp_rdata, exp_we, exp_data, r.addr);
          end
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
          n_vec++;
          if (rsp_perr !== exp_perr) begin
            n_err++;
            $display("FAIL rsp_perr: got %0b, expected %0b", rsp_perr, exp_perr);
          end
`else
          if (exp_perr !== 1'b0) $display("note: unexpected parity expectation");
`endif
        end
      end
      // Strobe invariants, every cycle.
      n_vec++;
      if (cell_w && cell_r) begin
        n_err++;
        $display("FAIL strobe_overlap: cell_w=1 and cell_r=1 at cycle %0d", cyc);
      end
      n_vec++;
      if ((cell_w || cell_r) ? ($countones(cell_cs) != 1) : (cell_cs != '0)) begin
        n_err++;
        $display("FAIL cs_onehot: cell_cs=%b with w=%0b r=%0b at cycle %0d", cell_cs, cell_w, cell_r, cyc);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered just after a rising edge; returns just after the edge that
  // begins the strobe cycle (N+1), having checked the strobe pins.
  task automatic do_access(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, output int acc_cyc);
    int n;
    logic [WORDS-1:0] exp_cs;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, n);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_cs = '0;
    exp_cs[addr] = 1'b1;
    n_vec++;
    if (cell_cs !== exp_cs || cell_w !== we || cell_r !== !we) begin
      n_err++;
      $display("FAIL strobe: cs=%b w=%0b r=%0b, expected cs=%b w=%0b r=%0b",
               cell_cs, cell_w, cell_r, exp_cs, we, !we);
    end
    if (we) begin
      n_vec++;
      if (cell_din[DATA_W-1:0] !== data) begin
        n_err++;
        $display("FAIL cell_din: got %h, expected %h", cell_din[DATA_W-1:0], data);
      end
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
      n_vec++;
      if (cell_din[CW-1] !== ^data) begin
        n_err++;
        $display("FAIL cell_din_parity: got %0b, expected %0b", cell_din[CW-1], ^data);
      end
`endif
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_we !== 1'b0 ||
        cell_cs !== '0 || cell_w !== 1'b0 || cell_r !== 1'b0 || cell_din !== '0) begin
      n_err++;
      $display("FAIL reset_state: ready=%0b rvalid=%0b rdata=%h rwe=%0b cs=%b w=%0b r=%0b din=%h, expected 1 0 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_we, cell_cs, cell_w, cell_r, cell_din);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    int c;
    do_access(1'b1, 2'd2, 4'hA, c);
    n_vec++;
    if (cell_cs !== 4'b0100 || cell_w !== 1'b1) begin
      n_err++;
      $display("FAIL wr_strobe_addr2: cs=%b w=%0b, expected 0100 1", cell_cs, cell_w);
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== 4'h0) begin
      n_err++;
      $display("FAIL wr_ack: valid=%0b we=%0b rdata=%h, expected 1 1 0", rsp_valid, rsp_we, rsp_rdata);
    end
    @(posedge clk); #1;
    do_access(1'b0, 2'd2, 4'h0, c);
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 4'hA) begin
      n_err++;
      $display("FAIL rd_addr2: valid=%0b we=%0b rdata=%h, expected 1 0 a", rsp_valid, rsp_we, rsp_rdata);
    end
    @(posedge clk); #1;
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL return_idle: ready=%0b rvalid=%0b, expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_sweep();
    int c;
    for (int k = 0; k < WORDS; k++) begin
      do_access(1'b1, ADDR_W'(k), 4'h5 ^ DATA_W'(k), c);
      repeat (2) @(posedge clk);
      #1;
    end
    for (int k = 0; k < WORDS; k++) begin
      do_access(1'b0, ADDR_W'(k), 4'h0, c);
      @(posedge clk); #1;
      n_vec++;
      if (rsp_rdata !== (4'h5 ^ DATA_W'(k))) begin
        n_err++;
        $display("FAIL sweep_read%0d: got %h, expected %h", k, rsp_rdata, 4'h5 ^ DATA_W'(k));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_access(1'b1, 2'd1, 4'hF, c);
    rst = 1'b1;
    #1;
    n_vec++;
    if (cell_cs !== '0 || cell_w !== 1'b0 || cell_din !== '0) begin
      n_err++;
      $display("FAIL reset_mid_strobe: cs=%b w=%0b din=%h, expected 0 0 0", cell_cs, cell_w, cell_din);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid_after: rvalid=%0b ready=%0b, expected 0 1", rsp_valid, req_ready);
      end
    end
    // The aborted write never reached the cells: addr 1 keeps 5^1.
    do_access(1'b0, 2'd1, 4'h0, c);
    @(posedge clk); #1;
    n_vec++;
    if (rsp_rdata !== 4'h4) begin
      n_err++;
      $display("FAIL reset_mid_readback: got %h, expected 4", rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int c;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp;
    a = ADDR_W'($urandom_range(0, WORDS - 1));
    rsp_ready = 1'b0;
    do_access(1'b0, a, 4'h0, c);
    exp = mem[a];
    @(posedge clk); #1;
    req_we    = 1'b1;
    req_addr  = a ^ 2'd1;
    req_wdata = DATA_W'($urandom);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_we !== 1'b0 ||
          req_ready !== 1'b0 || cell_w !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure%0d: rvalid=%0b rdata=%h rwe=%0b ready=%0b w=%0b, expected 1 %h 0 0 0",
                 i, rsp_valid, rsp_rdata, rsp_we, req_ready, cell_w, exp);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: rvalid=%0b ready=%0b, expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int prev;
    rsp_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 12; i++) begin
      do_access(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, WORDS - 1)),
                DATA_W'($urandom), c);
      if (prev >= 0) begin
        n_vec++;
        if (c - prev != 3) begin
          n_err++;
          $display("FAIL issue_interval%0d: got %0d cycles, expected 3", i, c - prev);
        end
      end
      prev = c;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (pend_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: %0d responses outstanding, expected 0", pend_q.size());
    end
  endtask

`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
  task automatic test_parity();
    int c;
    do_access(1'b1, 2'd1, 4'h7, c);
    repeat (2) @(posedge clk);
    #1;
    force_msb0 = 1'b1;
    do_access(1'b0, 2'd1, 4'h0, c);
    @(posedge clk); #1;
    force_msb0 = 1'b0;
    n_vec++;
    if (rsp_perr !== 1'b1 || rsp_rdata !== 4'h7) begin
      n_err++;
      $display("FAIL parity_forced: perr=%0b rdata=%h, expected 1 7", rsp_perr, rsp_rdata);
    end
    @(posedge clk); #1;
    do_access(1'b0, 2'd1, 4'h0, c);
    @(posedge clk); #1;
    n_vec++;
    if (rsp_perr !== 1'b0 || rsp_rdata !== 4'h7) begin
      n_err++;
      $display("FAIL parity_clean: perr=%0b rdata=%h, expected 0 7", rsp_perr, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_sweep();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
`ifdef BITCELL_ARRAY_CTRL_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
